// File: rtl/sweep_pkg.sv
// Shared types and default sizes for the counter sweep sequencer.
package sweep_pkg;

    localparam int SWEEP_WIDTH  = 8;
    localparam int SWEEP_PCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UP,
        ST_DOWN,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/sweep_range_cmp.sv
// Every magnitude comparison the sweep needs: turn-point detection on the
// fed-back count and the sanity check of a requested configuration.
module sweep_range_cmp
    import sweep_pkg::*;
#(
    parameter int WIDTH = SWEEP_WIDTH
) (
    input  logic [WIDTH-1:0] top,
    input  logic [WIDTH-1:0] bottom,
    input  logic [WIDTH-1:0] start_pt,
    input  logic [WIDTH-1:0] count,
    output logic             at_top,
    output logic             at_bottom,
    output logic             cfg_ok
);

    assign at_top    = (count == top);
    assign at_bottom = (count == bottom);
    assign cfg_ok    = (bottom < top) && (bottom <= start_pt) && (start_pt <= top);

endmodule

// File: rtl/sweep_controller.sv
// Sequencer that sweeps an external up/down counter between two turn points
// for a programmed number of periods, then pulses done.
//
// state | meaning
// IDLE  | counter held in reset, waiting for an acceptable start
// LOAD  | one cycle loading the start value into the counter
// UP    | counting up until count reaches the top bound
// DOWN  | counting down until count reaches the bottom bound
// DONE  | one-cycle done pulse, counter back in reset
module sweep_controller
    import sweep_pkg::*;
#(
    parameter int WIDTH  = SWEEP_WIDTH,
    parameter int PCNT_W = SWEEP_PCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  start_val,
    input  logic [WIDTH-1:0]  top_val,
    input  logic [WIDTH-1:0]  bottom_val,
    input  logic [PCNT_W-1:0] periods,
    input  logic [WIDTH-1:0]  count,
    output logic              ctr_rst,
    output logic              ctr_load,
    output logic [WIDTH-1:0]  ctr_data,
    output logic              ctr_up_down,
    output logic [WIDTH-1:0]  ctr_reset_variable,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PCNT_W-1:0] period_idx
);

    sweep_state_t      state;
    logic [WIDTH-1:0]  bottom_r;
    logic [PCNT_W-1:0] periods_r;

    logic [WIDTH-1:0]  cmp_top;
    logic [WIDTH-1:0]  cmp_bottom;
    logic [WIDTH-1:0]  cmp_start;
    logic              at_top;
    logic              at_bottom;
    logic              range_ok;
    logic              cfg_accept;
    logic              last_period;

    // In IDLE the comparator vets the raw request; afterwards it watches the
    // captured bounds (start and top live in ctr_data / ctr_reset_variable).
    always_comb begin
        cmp_top    = ctr_reset_variable;
        cmp_bottom = bottom_r;
        cmp_start  = ctr_data;
        if (state == ST_IDLE) begin
            cmp_top    = top_val;
            cmp_bottom = bottom_val;
            cmp_start  = start_val;
        end
    end

    sweep_range_cmp #(.WIDTH(WIDTH)) u_range_cmp (
        .top       (cmp_top),
        .bottom    (cmp_bottom),
        .start_pt  (cmp_start),
        .count     (count),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .cfg_ok    (range_ok)
    );

    assign cfg_accept  = range_ok && (periods != '0);
    assign last_period = ((period_idx + PCNT_W'(1)) == periods_r);

    // Turn-around must reach the counter in the same cycle the bound is seen.
    // On the final bottom the direction is also 1 so the count never dips below it.
    always_comb begin
        ctr_up_down = 1'b1;
        case (state)
            ST_UP:   ctr_up_down = ~at_top;
            ST_DOWN: ctr_up_down = at_bottom;
            default: ctr_up_down = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            bottom_r           <= '0;
            periods_r          <= '0;
            ctr_rst            <= 1'b1;
            ctr_load           <= 1'b0;
            ctr_data           <= '0;
            ctr_reset_variable <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            period_idx         <= '0;
        end else begin
            ctr_load <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_accept) begin
                            state              <= ST_LOAD;
                            ctr_data           <= start_val;
                            ctr_reset_variable <= top_val;
                            bottom_r           <= bottom_val;
                            periods_r          <= periods;
                            period_idx         <= '0;
                            ctr_rst            <= 1'b0;
                            ctr_load           <= 1'b1;
                            busy               <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        ctr_rst <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state <= ST_UP;
                    end
                end
                ST_UP: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        ctr_rst <= 1'b1;
                        busy    <= 1'b0;
                    end else if (at_top) begin
                        state <= ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        ctr_rst <= 1'b1;
                        busy    <= 1'b0;
                    end else if (at_bottom) begin
                        period_idx <= period_idx + PCNT_W'(1);
                        if (last_period) begin
                            state   <= ST_DONE;
                            ctr_rst <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state <= ST_UP;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    ctr_rst <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_controller.sv
// Scoreboard bench for sweep_controller driving a behavioural up/down counter.
module tb_sweep_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] start_val = '0;
    logic [7:0] top_val = '0;
    logic [7:0] bottom_val = '0;
    logic [3:0] periods = '0;
    logic [7:0] ctr_count;
    logic       ctr_rst, ctr_load, ctr_up_down, busy, done, err;
    logic [7:0] ctr_data, ctr_reset_variable;
    logic [3:0] period_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        int pidx;
    } cyc_t;

    typedef struct {
        int len;
        bit has_done;
        int pidx;
        int top;
    } txn_t;

    cyc_t exp_q[$];
    txn_t txn_q[$];
    int   err_q[$];

    always #5 clk = ~clk;

    sweep_controller #(.WIDTH(8), .PCNT_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .start_val          (start_val),
        .top_val            (top_val),
        .bottom_val         (bottom_val),
        .periods            (periods),
        .count              (ctr_count),
        .ctr_rst            (ctr_rst),
        .ctr_load           (ctr_load),
        .ctr_data           (ctr_data),
        .ctr_up_down        (ctr_up_down),
        .ctr_reset_variable (ctr_reset_variable),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .period_idx         (period_idx)
    );

    // Controlled datapath: synchronous reset, load, then count up or down.
    always @(posedge clk) begin
        if (ctr_rst)       ctr_count <= 8'd0;
        else if (ctr_load) ctr_count <= ctr_data;
        else if (ctr_up_down) ctr_count <= ctr_count + 8'd1;
        else               ctr_count <= ctr_count - 8'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cfg_valid(input int s, input int t, input int b, input int p);
        return (b < t) && (b <= s) && (s <= t) && (p != 0);
    endfunction

    task automatic push_cyc(input int c, input int pi);
        cyc_t x;
        x.cnt  = c;
        x.pidx = pi;
        exp_q.push_back(x);
    endtask

    task automatic push_txn(input int n, input bit d, input int pi, input int t);
        txn_t x;
        x.len = n;
        x.has_done = d;
        x.pidx = pi;
        x.top = t;
        txn_q.push_back(x);
    endtask

    // Expected count trace: load cycle, climb to top, then p descents with climbs between.
    task automatic push_sweep(input int s, input int t, input int b, input int p, input int abort_at);
        int n;
        n = 1;
        push_cyc(-1, 0);
        for (int v = s; v <= t; v++) begin
            push_cyc(v, 0);
            n++;
            if (v == abort_at) begin
                push_txn(n, 1'b0, 0, t);
                return;
            end
        end
        for (int k = 0; k < p; k++) begin
            for (int v = t - 1; v >= b; v--) begin
                push_cyc(v, k);
                n++;
            end
            if (k < p - 1) begin
                for (int v = b + 1; v <= t; v++) begin
                    push_cyc(v, k + 1);
                    n++;
                end
            end
        end
        push_txn(n, 1'b1, p, t);
    endtask

    // Monitor: consumes expectations whenever the DUT shows busy, done or err.
    bit in_run = 1'b0;
    int run_len = 0;
    always @(negedge clk) begin
        if (!rst) begin
            in_run  = 1'b0;
            run_len = 0;
        end else begin
            chk("ctr_rst_vs_busy", ctr_rst, !busy);
            if (busy) begin
                in_run = 1'b1;
                run_len++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy", 1, 0);
                end else begin
                    cyc_t e;
                    e = exp_q.pop_front();
                    if (e.cnt < 0) begin
                        chk("load_strobe", ctr_load, 1);
                    end else begin
                        chk("count", ctr_count, e.cnt);
                        chk("load_idle", ctr_load, 0);
                    end
                    chk("period_idx_run", period_idx, e.pidx);
                    if (txn_q.size() != 0) chk("reset_variable", ctr_reset_variable, txn_q[0].top);
                end
            end else if (in_run) begin
                in_run = 1'b0;
                if (txn_q.size() == 0) begin
                    chk("unexpected_end", 1, 0);
                end else begin
                    txn_t x;
                    x = txn_q.pop_front();
                    chk("busy_len", run_len, x.len);
                    chk("done_pulse", done, x.has_done);
                    if (x.has_done) chk("period_idx_end", period_idx, x.pidx);
                end
                run_len = 0;
            end else begin
                chk("stray_done", done, 0);
            end
            if (err) begin
                if (err_q.size() == 0) chk("unexpected_err", 1, 0);
                else void'(err_q.pop_front());
            end
        end
    end

    task automatic do_start(input int s, input int t, input int b, input int p);
        start_val  = s[7:0];
        top_val    = t[7:0];
        bottom_val = b[7:0];
        periods    = p[3:0];
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        start_val  = 8'($urandom);
        top_val    = 8'($urandom);
        bottom_val = 8'($urandom);
        periods    = 4'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || done) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, (busy || done) ? 1 : 0, 0);
    endtask

    task automatic run_cfg(input string name, input int s, input int t, input int b,
                           input int p, input int abort_at);
        if (cfg_valid(s, t, b, p)) push_sweep(s, t, b, p, abort_at);
        else err_q.push_back(1);
        do_start(s, t, b, p);
        if (abort_at >= 0) begin
            for (int i = 0; i < 400 && !(busy && ctr_count == abort_at[7:0]); i++) @(negedge clk);
            chk({name, "_abort_point"}, (busy && ctr_count == abort_at[7:0]) ? 1 : 0, 1);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        wait_idle(name);
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, "_ctr_rst"}, ctr_rst, 1);
        chk({name, "_ctr_load"}, ctr_load, 0);
        chk({name, "_ctr_data"}, ctr_data, 0);
        chk({name, "_up_down"}, ctr_up_down, 1);
        chk({name, "_reset_var"}, ctr_reset_variable, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_err"}, err, 0);
        chk({name, "_period_idx"}, period_idx, 0);
    endtask

    initial begin
        int s, t, b, p, lo, hi;
        repeat (2) @(negedge clk);
        chk_reset_values("por");
        #2 rst = 1'b1;
        @(negedge clk);

        run_cfg("single", 80, 99, 70, 1, -1);
        run_cfg("multi", 80, 99, 70, 2, -1);
        run_cfg("rej_bounds", 55, 50, 60, 1, -1);
        run_cfg("rej_start", 40, 90, 50, 1, -1);
        run_cfg("rej_periods", 80, 99, 70, 0, -1);
        run_cfg("edge", 10, 10, 9, 3, -1);
        run_cfg("abort", 80, 99, 70, 1, 85);
        run_cfg("after_abort", 80, 99, 70, 1, -1);

        // Asynchronous reset while counting down.
        push_sweep(80, 99, 70, 2, -1);
        do_start(80, 99, 70, 2);
        for (int i = 0; i < 200 && !(busy && ctr_count == 8'd99); i++) @(negedge clk);
        chk("rst_reach_top", (busy && ctr_count == 8'd99) ? 1 : 0, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_values("mid_rst");
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        txn_q.delete();
        err_q.delete();
        #2 rst = 1'b1;
        @(negedge clk);
        run_cfg("post_rst", 80, 99, 70, 1, -1);

        for (int i = 0; i < 30; i++) begin
            b  = $urandom_range(200, 0);
            t  = b + $urandom_range(30, 0);
            lo = (b >= 3) ? b - 3 : 0;
            hi = t + 3;
            s  = $urandom_range(hi, lo);
            p  = $urandom_range(4, 0);
            run_cfg("random", s, t, b, p, -1);
        end

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("txn_q_drained", txn_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sweep_controller.md
# sweep_controller

Sequencer for the 8-bit up/down `Counter` datapath in the comparator project.
- On a `start` pulse it captures a configuration, loads the counter with a start value, and drives `up_down` so the count sweeps up to a top bound, then down to a bottom bound, for a programmed number of periods.
- When finished it pulses `done`.
- It owns every control input of the counter: `rst`, `load`, `data`, `up_down`, `reset_variable`.

## Interface

Parameters:
- `WIDTH`, default 8: counter/data width.
- `PCNT_W`, default 4: width of the period count.

Ports:
- `clk`  in  1: single clock. Everything is on its rising edge.
- `rst`  in  1: reset, asynchronous and active-low. Forces state IDLE and all registers to their reset values.
- `start`  in  1: sampled in IDLE only; a 1 begins a sweep.
- `abort`  in  1: sampled in LOAD/UP/DOWN; a 1 ends the sweep without `done`.
- `start_val`  in  WIDTH: initial count, captured on start.
- `top_val`  in  WIDTH: upper turn point, captured on start.
- `bottom_val`  in  WIDTH: lower turn point, captured on start.
- `periods`  in  PCNT_W: number of down-turns before completion, captured on start.
- `count`  in  WIDTH: counter output, fed back.
- `ctr_rst`  out  1: active-high synchronous reset to the counter. Reset value 1.
- `ctr_load`  out  1: counter load strobe. Reset value 0.
- `ctr_data`  out  WIDTH: counter load data. Reset value 0.
- `ctr_up_down`  out  1: 1 = up, 0 = down. Reset value 1.
- `ctr_reset_variable`  out  WIDTH: equals the captured `top_val`. Reset value 0.
- `busy`  out  1: high in LOAD/UP/DOWN. Reset value 0.
- `done`  out  1: one-cycle pulse in DONE. Reset value 0.
- `err`  out  1: one-cycle pulse when `start` is rejected. Reset value 0.
- `period_idx`  out  PCNT_W: completed down-turns so far. Reset value 0.

## Operation

States: IDLE, LOAD, UP, DOWN, DONE.

Configuration check (IDLE, `start`=1):
- Accept only if `bottom_val < top_val`, `bottom_val <= start_val <= top_val`, and `periods != 0`.
- Rejected: `err` pulses the next cycle; state stays IDLE; nothing is captured.
- Accepted: capture all configuration into registers; clear `period_idx`; next state LOAD. Input changes while busy are ignored.

Per-state behaviour:
- **IDLE:** `ctr_rst`=1, `ctr_load`=0.
- **LOAD** (exactly 1 cycle): `ctr_rst`=0, `ctr_load`=1, `ctr_data`=start; next state UP.
- **UP:** `ctr_up_down` is 1, except when `count`==top, where it is 0 and the next state is DOWN.
- **DOWN:** `ctr_up_down` is 0 while `count`!=bottom. When `count`==bottom:
  - Increment `period_idx`.
  - If `period_idx`+1 == periods: next state DONE.
  - Otherwise `ctr_up_down`=1 and the next state is UP.
- **DONE** (1 cycle): `done`=1, `ctr_rst`=1; next state IDLE. `period_idx` holds until the next accepted start.
- **abort** in LOAD/UP/DOWN: next state IDLE, `ctr_rst`=1, no `done`. Abort has priority over every other transition.

Resulting count sequence:
- start, …, top, top−1, …, bottom, then bottom+1, …, top, … and so on.
- The counter never exceeds top or goes below bottom, so its internal wrap is never exercised.
- If start==top, UP lasts one cycle.

Other rules:
- `rst` asserted mid-sweep: immediate return to IDLE with reset values; no `done`.

## Timing

- Turn-around: `ctr_up_down` is combinational from `count` and the state. This creates a deliberate path from counter output back to counter input, which must close in one cycle. Every other output is registered.
- Start sampled at edge E0: LOAD is the cycle after E0; `count`==start_val in the cycle after that, in UP.
- Cycles in UP:
  - First period: top − start + 1.
  - Later periods: top − bottom.
- Cycles in DOWN, every period: top − bottom.
- Busy cycles = 1 + (top − start + 1) + (top − bottom)·(2·periods − 1). `done` occurs in the cycle immediately after the last busy cycle.
- `err` is one cycle after the rejected start.
- A new `start` is accepted in the first IDLE cycle after DONE.

## Structure

- Package `sweep_pkg`:
  - State encoding enum (IDLE, LOAD, UP, DOWN, DONE).
  - Default `WIDTH`/`PCNT_W` constants.
- Sub-module `sweep_range_cmp` (combinational):
  - Inputs: captured top/bottom/start and `count`.
  - Outputs: `at_top`, `at_bottom`, `cfg_ok`.
  - Holds all comparisons, in line with the comparator project.
- Top level: the FSM, configuration registers, and `period_idx`.
- The bench instantiates the existing `Counter` as the controlled datapath.

## Test plan

- **Single period:** start=80, top=99, bottom=70, periods=1.
  - Count goes 80→99→70.
  - `busy` lasts 1 + 20 + 29 = 50 cycles, then `done` for 1 cycle.
  - `period_idx`=1 at end.
- **Multi-period:** same bounds, periods=2.
  - Busy is 108 cycles; `done` is in the 109th cycle after the start edge.
  - Count never leaves [70, 99].
  - `period_idx` steps 0→1→2.
- **Rejection:** start with top=50, bottom=60; then start_val=40 with bottom=50, top=90; then periods=0.
  - Each gives a one-cycle `err`; `busy` stays 0; `ctr_rst` stays 1.
- **Edge bounds:** start=top=10, bottom=9, periods=3.
  - Count 10, 9, 10, 9, 10, 9.
  - UP lasts 1 cycle; `done` follows.
- **Abort:** abort asserted at count=85 during the first UP.
  - IDLE next cycle, `ctr_rst`=1, no `done`.
  - The following start runs normally.
- **Reset mid-sweep:** `rst` driven low asynchronously in DOWN.
  - All outputs at reset values before the next edge.
  - After release, a full sweep completes.
